// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg -- shared constants, counter encoding and BTB entry layout for
// the fetch PC generator.
package pc_gen_pkg;

    // Default boot address and default geometry of the generator.
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0040_0000;
    localparam int          DEF_XLEN         = 32;
    localparam int          DEF_INST_BYTES   = 4;
    localparam int          DEF_BTB_DEPTH    = 16;
    localparam int          DEF_TAG_W        = DEF_XLEN - $clog2(DEF_INST_BYTES) - $clog2(DEF_BTB_DEPTH);

    // Two-bit saturating direction counter; bit 1 is the taken prediction.
    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;  // strongly not-taken
    localparam ctr_t CTR_WNT = 2'b01;  // weakly not-taken (reset value)
    localparam ctr_t CTR_WT  = 2'b10;  // weakly taken (fresh allocation)
    localparam ctr_t CTR_ST  = 2'b11;  // strongly taken

    // Entry layout for the default geometry. The BTB declares the same
    // layout locally with its own tag width, since a package typedef
    // cannot follow a module parameter.
    typedef struct packed {
        logic                 valid;
        logic [DEF_TAG_W-1:0] tag;
        logic [DEF_XLEN-1:0]  target;
        ctr_t                 ctr;
    } btb_entry_t;

    // Saturating counter step: up on taken, down on not-taken.
    function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
        ctr_t res;
        res = cur;
        if (taken && cur != CTR_ST) begin
            res = cur + 2'b01;
        end else if (!taken && cur != CTR_SNT) begin
            res = cur - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if -- control, redirect, branch-update and PC output signals of the
// fetch PC generator. The master side is the pipeline control; the slave side
// is pc_gen itself. Clock and reset are not part of this bundle.
interface pc_gen_if #(
    parameter int XLEN = 32
);

    logic            en;
    logic            stall;
    logic            flush;
    logic [XLEN-1:0] flush_target;

    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;

    logic [XLEN-1:0] pc;
    logic            pred_taken;

    modport master (
        output en, stall, flush, flush_target,
        output upd_valid, upd_pc, upd_taken, upd_target,
        input  pc, pred_taken
    );

    modport slave (
        input  en, stall, flush, flush_target,
        input  upd_valid, upd_pc, upd_taken, upd_target,
        output pc, pred_taken
    );

endinterface

// File: rtl/pc_gen_btb.sv
// pc_gen_btb -- direct-mapped branch target buffer with 2-bit saturating
// direction counters. Lookup is combinational on lookup_pc; updates are
// written on the clock edge, so a lookup in the same cycle as an update sees
// the old contents.
module pc_gen_btb
    import pc_gen_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int INST_BYTES = 4,
    parameter int BTB_DEPTH  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,

    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,

    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target
);

    localparam int OFF   = $clog2(INST_BYTES);
    localparam int IW    = $clog2(BTB_DEPTH);
    localparam int TAG_W = XLEN - OFF - IW;

    typedef logic [IW-1:0]    idx_t;
    typedef logic [TAG_W-1:0] tag_t;

    // Same field order as pc_gen_pkg::btb_entry_t, sized for this instance.
    typedef struct packed {
        logic            valid;
        tag_t            tag;
        logic [XLEN-1:0] target;
        ctr_t            ctr;
    } entry_t;

    // Storage is split so that only valid and ctr carry a reset.
    logic [BTB_DEPTH-1:0] valid_q;
    ctr_t                 ctr_q    [BTB_DEPTH];
    tag_t                 tag_q    [BTB_DEPTH];
    logic [XLEN-1:0]      target_q [BTB_DEPTH];

    idx_t   l_idx;
    tag_t   l_tag;
    entry_t l_entry;
    logic   l_hit;

    idx_t   u_idx;
    tag_t   u_tag;
    logic   u_hit;
    logic   upd_we;

    // The offset bits never reach the table; fold them here so every input
    // bit is visibly consumed.
    logic   unused_offset_bits;
    assign  unused_offset_bits = ^{lookup_pc, upd_pc};

    // Address split into index and tag for lookup and update.
    assign l_idx = lookup_pc[OFF+IW-1:OFF];
    assign l_tag = lookup_pc[XLEN-1:OFF+IW];
    assign u_idx = upd_pc[OFF+IW-1:OFF];
    assign u_tag = upd_pc[XLEN-1:OFF+IW];

    // Lookup: read the indexed entry and qualify it with the tag.
    assign l_entry     = '{valid:  valid_q[l_idx],
                           tag:    tag_q[l_idx],
                           target: target_q[l_idx],
                           ctr:    ctr_q[l_idx]};
    assign l_hit       = l_entry.valid && (l_entry.tag == l_tag);
    assign pred_taken  = l_hit && l_entry.ctr[1];
    assign pred_target = l_entry.target;

    // Update probe uses the same hit rule against the resolved PC.
    assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign upd_we = en && upd_valid;

    // Valid bits and counters: cleared on reset, trained on resolved branches.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; that is also what gives read-before-write here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < BTB_DEPTH; i++) begin
                ctr_q[i] <= CTR_WNT;
            end
        end else if (upd_we) begin
            if (u_hit) begin
                ctr_q[u_idx] <= ctr_next(ctr_q[u_idx], upd_taken);
            end else if (upd_taken) begin
                valid_q[u_idx] <= 1'b1;
                ctr_q[u_idx]   <= CTR_WT;
            end
        end
    end

    // Tag and target payload: written on any taken update (rewriting an
    // identical tag on a hit is harmless).
    // NOTE: this array has no reset on purpose; a cleared valid bit already
    // hides whatever it holds, so it can map to plain RAM without reset muxes.
    always_ff @(posedge clk) begin
        if (rst && upd_we && upd_taken) begin
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= upd_target;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen -- fetch program counter generator with an optional branch target
// buffer. Define PC_GEN_BTB_EN to build the BTB; without it pred_taken is
// tied low, the next PC is always pc + INST_BYTES and the upd_* inputs are
// ignored.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter int              INST_BYTES   = 4,
    parameter int              BTB_DEPTH    = 16
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.slave  bus
);

    // Clears the offset bits of a redirect so fetch stays instruction aligned.
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INST_BYTES - 1));

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] npc;
    logic            btb_taken;
    logic [XLEN-1:0] btb_target;

`ifdef PC_GEN_BTB_EN
    pc_gen_btb #(
        .XLEN       (XLEN),
        .INST_BYTES (INST_BYTES),
        .BTB_DEPTH  (BTB_DEPTH)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .en          (bus.en),
        .lookup_pc   (pc_q),
        .pred_taken  (btb_taken),
        .pred_target (btb_target),
        .upd_valid   (bus.upd_valid),
        .upd_pc      (bus.upd_pc),
        .upd_taken   (bus.upd_taken),
        .upd_target  (bus.upd_target)
    );
`else
    // No predictor: always fall through, and swallow the update bus.
    logic unused_upd;
    assign unused_upd = ^{bus.upd_valid, bus.upd_pc, bus.upd_taken, bus.upd_target};
    assign btb_taken  = 1'b0;
    assign btb_target = '0;
`endif

    // Sequential successor wraps modulo 2^XLEN by truncation.
    assign seq_pc = pc_q + XLEN'(INST_BYTES);

    // Next-PC select: predicted target on a taken hit, else fall-through.
    // NOTE: every output of a combinational block gets a default first so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        npc = seq_pc;
        if (btb_taken) begin
            npc = btb_target;
        end
    end

    // PC register with priority reset > freeze > flush > stall > advance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q <= RESET_VECTOR;
        end else if (bus.en) begin
            if (bus.flush) begin
                pc_q <= bus.flush_target & ALIGN_MASK;
            end else if (!bus.stall) begin
                pc_q <= npc;
            end
        end
    end

    assign bus.pc         = pc_q;
    assign bus.pred_taken = btb_taken;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen -- directed scoreboard bench for pc_gen. Each step drives one
// cycle of inputs, queues the PC and prediction expected after that edge,
// then pops and compares just after the edge. Expectations adapt to whether
// PC_GEN_BTB_EN is defined.
module tb_pc_gen;

`ifdef PC_GEN_BTB_EN
    localparam bit BTB = 1'b1;
`else
    localparam bit BTB = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic        pred;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    pc_gen_if #(.XLEN(32)) bus ();

    pc_gen #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0040_0000),
        .INST_BYTES   (4),
        .BTB_DEPTH    (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Pick the expected PC for BTB and no-BTB builds.
    function automatic logic [31:0] sel(input logic [31:0] with_btb, input logic [31:0] without_btb);
        return BTB ? with_btb : without_btb;
    endfunction

    // One cycle: drive on the falling edge, queue the expectation, compare
    // 1 ns after the rising edge.
    task automatic step(
        input string       tag,
        input logic        r,
        input logic        e,
        input logic        s,
        input logic        f,
        input logic [31:0] ft,
        input logic        uv,
        input logic [31:0] up,
        input logic        ut,
        input logic [31:0] utg,
        input logic [31:0] exp_pc,
        input logic        exp_pred
    );
        exp_t want;
        @(negedge clk);
        rst              = r;
        bus.en           = e;
        bus.stall        = s;
        bus.flush        = f;
        bus.flush_target = ft;
        bus.upd_valid    = uv;
        bus.upd_pc       = up;
        bus.upd_taken    = ut;
        bus.upd_target   = utg;
        sb.push_back('{pc: exp_pc, pred: exp_pred});
        @(posedge clk);
        #1;
        want = sb.pop_front();
        vectors++;
        assert (bus.pc === want.pc) else begin
            miscompares++;
            $error("FAIL %s pc: observed %h expected %h", tag, bus.pc, want.pc);
        end
        vectors++;
        assert (bus.pred_taken === want.pred) else begin
            miscompares++;
            $error("FAIL %s pred_taken: observed %b expected %b", tag, bus.pred_taken, want.pred);
        end
    endtask

    // Hard time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset for two cycles; the second also tries flush and an update,
        // which reset must override.
        step("rst0",    0, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0040_0000, 0);
        step("rst1",    0, 1, 0, 1, 32'h1234_0000, 1, 32'h0040_0000, 1, 32'h0050_0000, 32'h0040_0000, 0);
        step("adv4",    1, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0040_0004, 0);
        step("adv8",    1, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0040_0008, 0);
        step("stall",   1, 1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0040_0008, 0);
        step("flushst", 1, 1, 1, 1, 32'h0040_1003, 0, 32'h0,         0, 32'h0,         32'h0040_1000, 0);
        step("postfl",  1, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0040_1004, 0);

        // Train: allocate 0040_0010 -> 0040_0100, then fetch up to it.
        step("alloc",   1, 1, 0, 1, 32'h0040_0000, 1, 32'h0040_0010, 1, 32'h0040_0100, 32'h0040_0000, 0);
        step("walk4",   1, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0040_0004, 0);
        step("walk8",   1, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0040_0008, 0);
        step("walkC",   1, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0040_000C, 0);
        step("hit10",   1, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0040_0010, BTB);
        step("jump",    1, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         sel(32'h0040_0100, 32'h0040_0014), 0);

        // Saturate with three taken updates, then detrain with two not-taken.
        step("ret10",   1, 1, 0, 1, 32'h0040_0010, 0, 32'h0,         0, 32'h0,         32'h0040_0010, BTB);
        step("t1",      1, 1, 1, 0, 32'h0,         1, 32'h0040_0010, 1, 32'h0040_0100, 32'h0040_0010, BTB);
        step("t2",      1, 1, 1, 0, 32'h0,         1, 32'h0040_0010, 1, 32'h0040_0100, 32'h0040_0010, BTB);
        step("t3",      1, 1, 1, 0, 32'h0,         1, 32'h0040_0010, 1, 32'h0040_0100, 32'h0040_0010, BTB);
        step("nt1",     1, 1, 1, 0, 32'h0,         1, 32'h0040_0010, 0, 32'h0,         32'h0040_0010, BTB);
        step("nt2",     1, 1, 1, 0, 32'h0,         1, 32'h0040_0010, 0, 32'h0,         32'h0040_0010, 0);
        step("fallthr", 1, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0040_0014, 0);

        // Read-before-write: the update lands in the cycle that looks it up.
        step("ret10b",  1, 1, 0, 1, 32'h0040_0010, 0, 32'h0,         0, 32'h0,         32'h0040_0010, 0);
        step("rbw",     1, 1, 0, 0, 32'h0,         1, 32'h0040_0010, 1, 32'h0040_0200, 32'h0040_0014, 0);
        step("ret10c",  1, 1, 0, 1, 32'h0040_0010, 0, 32'h0,         0, 32'h0,         32'h0040_0010, BTB);
        step("newtgt",  1, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         sel(32'h0040_0200, 32'h0040_0014), 0);

        // Alias at the same index with a different tag.
        step("alias",   1, 1, 0, 1, 32'h0040_0050, 0, 32'h0,         0, 32'h0,         32'h0040_0050, 0);
        step("aliasnx", 1, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0040_0054, 0);

        // Not-taken miss leaves the table alone.
        step("ntmiss",  1, 1, 0, 1, 32'h0040_0010, 1, 32'h0040_0090, 0, 32'h0,         32'h0040_0010, BTB);

        // Disabled: flush and update both ignored.
        step("en0",     1, 0, 0, 1, 32'h0000_1000, 1, 32'h0040_0010, 0, 32'h0,         32'h0040_0010, BTB);
        step("en1",     1, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         sel(32'h0040_0200, 32'h0040_0014), 0);

        // Wrap at the top of the address space.
        step("top",     1, 1, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,         0, 32'h0,         32'hFFFF_FFFC, 0);
        step("wrap",    1, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0000_0000, 0);

        // Taken miss overwrites the aliasing entry.
        step("ovwr",    1, 1, 0, 1, 32'h0040_0010, 1, 32'h0040_0050, 1, 32'h0040_0300, 32'h0040_0010, 0);
        step("ovhit",   1, 1, 0, 1, 32'h0040_0050, 0, 32'h0,         0, 32'h0,         32'h0040_0050, BTB);
        step("ovjump",  1, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         sel(32'h0040_0300, 32'h0040_0054), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
